smpl_iter: RTL and testbench
============================

SMPL_ITER -- requirements
Module: smpl_iter

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits in each position/color word.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits; legal range is RADIX >= 10.
REQ-003 SHALL have parameter VERTS, default 3, meaning vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, meaning axes per vertex.
REQ-005 SHALL have parameter COLORS, default 3, meaning color channels.
REQ-006 SHALL have ports as follows (clock and reset first):
- clk, in, 1, the single clock.
- rst, in, 1, reset, asynchronous, active-low.
- tri_R13S, in, signed [SIGFIG-1:0][VERTS][AXIS], triangle vertices.
- color_R13U, in, [SIGFIG-1:0][COLORS], triangle color.
- box_R13S, in, signed [SIGFIG-1:0][2][2]; [0] is lower-left, [1] is upper-right, [.][0] is x.
- validTri_R13H, in, 1, box offered.
- halt_RnnnnL, out, 1, high when the block accepts a box (ready).
- subSample_RnnnnU, in, 4, one-hot; bits [0]/[1]/[2]/[3] give ss_w_lg2 = 3/2/1/0.
- halt_R14L, in, 1, downstream ready; low stalls.
- validSamp_R14H, out, 1, sample valid.
- tri_R14S and color_R14U, out, the held triangle and color.
- s_x_R14S and s_y_R14S, out, signed [SIGFIG-1:0], unjittered sample.
- jitter_x_R14S and jitter_y_R14S, out, signed [7:0], hash jitter.
- sample_R14S, out, signed [SIGFIG-1:0][2], jittered sample (s_j).

Function
REQ-007 SHALL implement a 2-state FSM:
- WAIT: halt_RnnnnL=1, validSamp_R14H=0.
- ITER: halt_RnnnnL=0.
REQ-008 SHALL accept a box in WAIT when validTri_R13H=1.
- On accept, SHALL register tri, color, box and ss_w_lg2.
- ss_w_lg2 SHALL be sampled only at accept.
REQ-009 SHALL define pitch = 1 << (RADIX - ss_w_lg2).
REQ-010 SHALL emit the first sample at s = box lower-left, with validSamp_R14H=1 the cycle after accept.
REQ-011 SHALL advance the sample on each cycle where validSamp_R14H & halt_R14L.
- x += pitch.
- If the new x > ur_x: x = ll_x and y += pitch.
- If the new y > ur_y: return to WAIT.
REQ-012 SHALL hold every R14 output stable while validSamp_R14H=1 and halt_R14L=0.
REQ-013 SHALL treat a box with ur_x < ll_x or ur_y < ll_y as invalid.
- It is accepted, emits zero samples, and the FSM returns to WAIT the next cycle.
REQ-014 SHALL treat a box with ll == ur as emitting exactly one sample.
REQ-015 SHALL compute the hash combinationally:
- a = s_x[RADIX+3:RADIX-3] and b = s_y[RADIX+3:RADIX-3].
- jitter_x = {0, a ^ {b[3:0], b[6:4]}}.
- jitter_y = {0, b ^ {a[2:0], a[6:3]}}.
REQ-016 SHALL compute s_j = s + (jitter << (RADIX-7-ss_w_lg2)), which guarantees the offset is < pitch.
- The add SHALL be signed SIGFIG-bit and wrap-free for on-screen boxes.
REQ-017 SHALL return to WAIT in the cycle after the last sample handshake.
- No sample SHALL be emitted twice.
- Back-to-back boxes SHALL incur exactly one idle WAIT cycle.

Reset
REQ-018 SHALL, on rst=0, asynchronously force:
- FSM to WAIT;
- validSamp_R14H=0 and halt_RnnnnL=1;
- every datapath register to 0.
REQ-019 SHALL discard an in-flight box on mid-iteration reset and emit nothing for it after rst is released.

Structure
REQ-020 SHALL place the following in a shared package smpl_pkg:
- the state enum (WAIT, ITER);
- ss_w_lg2 decode function;
- the JITTER_W=8 constant.
REQ-021 SHALL put the hash plus jitter add in one combinational sub-module, smpl_hash.
- smpl_hash SHALL be reusable by the sample-count scoreboard model.

Verification
REQ-022 SHALL cover a 4x subsample sweep:
- Stimulus: RADIX=10, subSample=0100, box (0,0)-(1024,1024), halt_R14L=1.
- Response: 9 samples, x in {0,512,1024} inner, y outer.
- Second sample: jitter=(4,64), s_j=(528,256).
REQ-023 SHALL cover a degenerate box: box (2048,2048)-(2048,2048) -> exactly one validSamp_R14H pulse, then halt_RnnnnL=1.
REQ-024 SHALL cover an invalid box: box (1024,0)-(0,1024) -> zero samples; halt_RnnnnL low for one cycle, then high.
REQ-025 SHALL cover stall: halt_R14L=0 for 5 cycles on the 3rd sample -> R14 outputs unchanged, with no skip and no duplicate.
REQ-026 SHALL cover reset mid-operation: rst=0 during the 4th sample of REQ-022 -> validSamp_R14H=0 immediately, FSM in WAIT, no further samples.
REQ-027 SHALL cover a hash check: every valid sample matches the check_hash reference, and the per-box sample count equals ((ur-ll)/pitch+1)^2 for square boxes.

Source files
------------

// File: rtl/smpl_pkg.sv
// -----------------------------------------------------------------------------
// smpl_pkg
//
// Shared definitions for the sample iterator and its hash/jitter helper.
//
//   smpl_state_e : iterator FSM state (WAIT = idle/ready, ITER = walking box)
//   JITTER_W     : width of each jitter component (sign bit + 7 hash bits)
//   HASH_W       : number of sample-position bits folded into the hash
//   ss_decode()  : one-hot subsample select -> log2 of samples per pixel axis
// -----------------------------------------------------------------------------
package smpl_pkg;

    localparam int JITTER_W = 8;
    localparam int HASH_W   = 7;

    typedef enum logic {
        WAIT = 1'b0,
        ITER = 1'b1
    } smpl_state_e;

    // One-hot subsample select: bit0 -> 8 samples/axis (lg2 3) down to
    // bit3 -> 1 sample/axis (lg2 0). A non-one-hot value resolves to the
    // lowest set bit; all-zero falls back to one sample per pixel.
    function automatic logic [1:0] ss_decode(input logic [3:0] sub_sample);
        logic [1:0] lg2;
        if (sub_sample[0]) begin
            lg2 = 2'd3;
        end else if (sub_sample[1]) begin
            lg2 = 2'd2;
        end else if (sub_sample[2]) begin
            lg2 = 2'd1;
        end else begin
            lg2 = 2'd0;
        end
        return lg2;
    endfunction

endpackage

// File: rtl/smpl_hash.sv
// -----------------------------------------------------------------------------
// smpl_hash
//
// Purely combinational sample-position hash and jitter offset.
//
// Seven bits around the binary point of each coordinate (a from x, b from y)
// are cross-mixed with rotations of the other axis to form a 7-bit jitter per
// axis. The jitter is scaled so its largest value stays below one sample
// pitch, then added to the unjittered position.
//
// Ports
//   s_x, s_y  : in  signed [SIGFIG-1:0]  unjittered sample position
//   ss_w_lg2  : in  [1:0]                log2 samples per pixel axis
//   jitter_x  : out signed [7:0]         x jitter (msb always 0)
//   jitter_y  : out signed [7:0]         y jitter (msb always 0)
//   sample    : out [1:0][SIGFIG-1:0]    jittered sample, [0] = x, [1] = y
// -----------------------------------------------------------------------------
module smpl_hash
    import smpl_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10
) (
    input  logic signed [SIGFIG-1:0]          s_x,
    input  logic signed [SIGFIG-1:0]          s_y,
    input  logic        [1:0]                 ss_w_lg2,
    output logic signed [JITTER_W-1:0]        jitter_x,
    output logic signed [JITTER_W-1:0]        jitter_y,
    output logic signed [1:0][SIGFIG-1:0]     sample
);

    logic [HASH_W-1:0] hash_a;
    logic [HASH_W-1:0] hash_b;
    logic [7:0]        jit_shift;
    logic [SIGFIG-1:0] off_x;
    logic [SIGFIG-1:0] off_y;

    always_comb begin
        // Bits RADIX+3 .. RADIX-3: the low integer bits plus the top
        // fraction bits, i.e. the part that varies between nearby samples.
        hash_a = s_x[RADIX+3 -: HASH_W];
        hash_b = s_y[RADIX+3 -: HASH_W];

        jitter_x = {1'b0, hash_a ^ {hash_b[3:0], hash_b[6:4]}};
        jitter_y = {1'b0, hash_b ^ {hash_a[2:0], hash_a[6:3]}};

        // A 7-bit jitter shifted by RADIX-7-ss_w_lg2 tops out just under
        // the pitch 1 << (RADIX-ss_w_lg2), so s_j never reaches the next
        // sample. RADIX >= 10 keeps this shift non-negative.
        jit_shift = 8'(RADIX - 7) - {6'd0, ss_w_lg2};

        off_x = {{(SIGFIG-JITTER_W){1'b0}}, jitter_x} << jit_shift;
        off_y = {{(SIGFIG-JITTER_W){1'b0}}, jitter_y} << jit_shift;

        sample[0] = s_x + off_x;
        sample[1] = s_y + off_y;
    end

endmodule

// File: rtl/smpl_iter.sv
// -----------------------------------------------------------------------------
// smpl_iter
//
// Walks a triangle's bounding box on a regular sample grid and emits one
// jittered sample per downstream handshake.
//
// Handshake rules (both sides):
//   upstream   : a box transfers on a cycle where validTri_R13H = 1 and
//                halt_RnnnnL = 1 (halt_RnnnnL is the ready signal).
//   downstream : a sample transfers on a cycle where validSamp_R14H = 1 and
//                halt_R14L = 1. While validSamp_R14H = 1 and halt_R14L = 0
//                every R14 output is held.
//
// Grid: samples start at the box lower-left and step by
// pitch = 1 << (RADIX - ss_w_lg2); x is the inner loop, y the outer. A box
// whose upper-right lies below/left of its lower-left is accepted but emits
// nothing, spending a single ITER cycle.
//
// Ports
//   clk               : in   clock
//   rst               : in   asynchronous active-low reset
//   tri_R13S          : in   triangle vertices [VERTS][AXIS] x SIGFIG
//   color_R13U        : in   triangle color [COLORS] x SIGFIG
//   box_R13S          : in   bounding box, [0] lower-left, [1] upper-right,
//                            [.][0] = x, [.][1] = y
//   validTri_R13H     : in   box offered
//   halt_RnnnnL       : out  ready for a box (high in WAIT)
//   subSample_RnnnnU  : in   one-hot subsample select, sampled at accept
//   halt_R14L         : in   downstream ready
//   validSamp_R14H    : out  sample valid
//   tri_R14S          : out  held triangle
//   color_R14U        : out  held color
//   s_x_R14S/s_y_R14S : out  unjittered sample
//   jitter_x/y_R14S   : out  hash jitter
//   sample_R14S       : out  jittered sample, [0] = x, [1] = y
// -----------------------------------------------------------------------------
module smpl_iter
    import smpl_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]     color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]       box_R13S,
    input  logic                                     validTri_R13H,
    output logic                                     halt_RnnnnL,
    input  logic        [3:0]                        subSample_RnnnnU,
    input  logic                                     halt_R14L,
    output logic                                     validSamp_R14H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]     color_R14U,
    output logic signed [SIGFIG-1:0]                 s_x_R14S,
    output logic signed [SIGFIG-1:0]                 s_y_R14S,
    output logic signed [7:0]                        jitter_x_R14S,
    output logic signed [7:0]                        jitter_y_R14S,
    output logic signed [1:0][SIGFIG-1:0]            sample_R14S
);

    localparam logic [SIGFIG:0] PITCH_ONE = {{SIGFIG{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and held box
    // ------------------------------------------------------------------
    smpl_state_e state;
    smpl_state_e state_nxt;

    logic signed [SIGFIG-1:0] ll_x_q;
    logic signed [SIGFIG-1:0] ll_y_q;
    logic signed [SIGFIG-1:0] ur_x_q;
    logic signed [SIGFIG-1:0] ur_y_q;
    logic        [1:0]        ss_w_lg2_q;
    logic                     box_ok_q;

    // FSM strobes
    logic accept;
    logic step;

    // Grid arithmetic, one bit wider than a position so stepping past a
    // box edge near the top of the range cannot wrap and look "inside".
    logic        [SIGFIG:0]   pitch;
    logic signed [SIGFIG:0]   x_inc;
    logic signed [SIGFIG:0]   y_inc;
    logic                     x_past;
    logic                     y_past;
    logic                     box_in_ok;

    always_comb begin
        pitch  = PITCH_ONE << (8'(RADIX) - {6'd0, ss_w_lg2_q});
        x_inc  = $signed({s_x_R14S[SIGFIG-1], s_x_R14S}) + $signed(pitch);
        y_inc  = $signed({s_y_R14S[SIGFIG-1], s_y_R14S}) + $signed(pitch);
        x_past = x_inc > $signed({ur_x_q[SIGFIG-1], ur_x_q});
        y_past = y_inc > $signed({ur_y_q[SIGFIG-1], ur_y_q});
    end

    // Validity of the box being offered, captured at accept so ITER knows
    // immediately whether there is anything to emit.
    always_comb begin
        box_in_ok = ($signed(box_R13S[1][0]) >= $signed(box_R13S[0][0])) &&
                    ($signed(box_R13S[1][1]) >= $signed(box_R13S[0][1]));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        step           = 1'b0;
        halt_RnnnnL    = 1'b0;
        validSamp_R14H = 1'b0;
        case (state)
            WAIT: begin
                halt_RnnnnL = 1'b1;
                if (validTri_R13H) begin
                    accept    = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                if (!box_ok_q) begin
                    // Empty box: one ITER cycle, nothing emitted.
                    state_nxt = WAIT;
                end else begin
                    validSamp_R14H = 1'b1;
                    if (halt_R14L) begin
                        step = 1'b1;
                        // Last sample: stepping wraps x and pushes y past
                        // the top edge.
                        if (x_past && y_past) begin
                            state_nxt = WAIT;
                        end
                    end
                end
            end
            default: begin
                state_nxt = WAIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_R14S   <= '0;
            color_R14U <= '0;
            ll_x_q     <= '0;
            ll_y_q     <= '0;
            ur_x_q     <= '0;
            ur_y_q     <= '0;
            ss_w_lg2_q <= 2'd0;
            box_ok_q   <= 1'b0;
            s_x_R14S   <= '0;
            s_y_R14S   <= '0;
        end else if (accept) begin
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_x_q     <= box_R13S[0][0];
            ll_y_q     <= box_R13S[0][1];
            ur_x_q     <= box_R13S[1][0];
            ur_y_q     <= box_R13S[1][1];
            ss_w_lg2_q <= ss_decode(subSample_RnnnnU);
            box_ok_q   <= box_in_ok;
            s_x_R14S   <= box_R13S[0][0];
            s_y_R14S   <= box_R13S[0][1];
        end else if (step) begin
            if (x_past) begin
                s_x_R14S <= ll_x_q;
                s_y_R14S <= y_inc[SIGFIG-1:0];
            end else begin
                s_x_R14S <= x_inc[SIGFIG-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hash and jitter on the current sample
    // ------------------------------------------------------------------
    smpl_hash #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX)
    ) u_hash (
        .s_x      (s_x_R14S),
        .s_y      (s_y_R14S),
        .ss_w_lg2 (ss_w_lg2_q),
        .jitter_x (jitter_x_R14S),
        .jitter_y (jitter_y_R14S),
        .sample   (sample_R14S)
    );

endmodule

// File: tb/tb_smpl_iter.sv
// -----------------------------------------------------------------------------
// tb_smpl_iter
//
// Scoreboarded bench for smpl_iter. The box driver expands each box into its
// expected sample stream with plain nested loops and a spec-level hash
// function; a negedge monitor pops and compares on every sample handshake
// and compares against the queue head while downstream stalls.
// -----------------------------------------------------------------------------
module tb_smpl_iter;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int W      = 4*SIGFIG + 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_in;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_in;
    logic                                          valid_tri;
    logic                                          halt_RnnnnL;
    logic        [3:0]                             sub_sample;
    logic                                          halt_R14L;
    logic                                          validSamp_R14H;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_out;
    logic signed [SIGFIG-1:0]                      s_x_out;
    logic signed [SIGFIG-1:0]                      s_y_out;
    logic signed [7:0]                             jit_x_out;
    logic signed [7:0]                             jit_y_out;
    logic signed [1:0][SIGFIG-1:0]                 sample_out;

    smpl_iter #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .halt_RnnnnL      (halt_RnnnnL),
        .subSample_RnnnnU (sub_sample),
        .halt_R14L        (halt_R14L),
        .validSamp_R14H   (validSamp_R14H),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .s_x_R14S         (s_x_out),
        .s_y_R14S         (s_y_out),
        .jitter_x_R14S    (jit_x_out),
        .jitter_y_R14S    (jit_y_out),
        .sample_R14S      (sample_out)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int box_hs   = 0;
    logic [W-1:0]  exp_q[$];
    logic [63:0]   obs_q[$];
    int            hs_cyc_q[$];
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] exp_tri;
    logic        [COLORS-1:0][SIGFIG-1:0]          exp_color;
    bit            rand_stall = 1'b0;
    logic [W-1:0]  mon_act;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference sample: hash from the coordinate bits around the binary
    // point, jitter scaled below one pitch. Record = {s_x,s_y,sj_x,sj_y,jx,jy}.
    function automatic logic [W-1:0] model_sample(input int x, input int y, input int ss);
        int a, b, jx, jy, sh;
        logic [SIGFIG-1:0] vx, vy, vjx, vjy;
        logic [7:0] jx8, jy8;
        a   = (x >>> (RADIX - 3)) & 127;
        b   = (y >>> (RADIX - 3)) & 127;
        jx  = a ^ (((b & 15) << 3) | (b >> 4));
        jy  = b ^ (((a & 7) << 4) | (a >> 3));
        sh  = RADIX - 7 - ss;
        vx  = SIGFIG'(x);
        vy  = SIGFIG'(y);
        vjx = SIGFIG'(x + (jx << sh));
        vjy = SIGFIG'(y + (jy << sh));
        jx8 = 8'(jx);
        jy8 = 8'(jy);
        return {vx, vy, vjx, vjy, jx8, jy8};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_box(input int llx, input int lly, input int urx, input int ury,
                            input int ss_idx);
        int ss, pitch, n;
        ss    = 3 - ss_idx;
        pitch = 1 << (RADIX - ss);
        n = 0;
        while (!halt_RnnnnL && n < 200) begin
            step();
            n++;
        end
        chk("accept_ready", halt_RnnnnL, 1);
        for (int v = 0; v < VERTS; v++)
            for (int k = 0; k < AXIS; k++)
                tri_in[v][k] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_in[c] = SIGFIG'($urandom);
        exp_tri      = tri_in;
        exp_color    = color_in;
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        sub_sample   = 4'b0001 << ss_idx;
        for (int y = lly; y <= ury; y += pitch)
            for (int x = llx; x <= urx; x += pitch)
                exp_q.push_back(model_sample(x, y, ss));
        box_hs = 0;
        obs_q.delete();
        valid_tri = 1'b1;
        step();
        valid_tri = 1'b0;
        // Scramble inputs: the held box must come only from the accept cycle.
        box_in     = {4{SIGFIG'($urandom)}};
        sub_sample = 4'b0001 << $urandom_range(0, 3);
        tri_in     = '0;
        color_in   = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !halt_RnnnnL) && n < 2000) begin
            step();
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        chk({name, "_idle"}, halt_RnnnnL, 1);
    endtask

    // ---------------- downstream ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) halt_R14L = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && validSamp_R14H) begin
            mon_act = {s_x_out, s_y_out, sample_out[0], sample_out[1], jit_x_out, jit_y_out};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample act=%0h exp=none", mon_act);
            end else if (halt_R14L) begin
                chk("sample", mon_act, exp_q.pop_front());
                chk("tri", tri_out, exp_tri);
                chk("color", color_out, exp_color);
                box_hs++;
                obs_q.push_back(mon_act[63:0]);
                hs_cyc_q.push_back(cyc);
            end else begin
                chk("stall_hold", mon_act, exp_q[0]);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst        = 1'b0;
        valid_tri  = 1'b0;
        halt_R14L  = 1'b1;
        sub_sample = 4'b0100;
        box_in     = '0;
        tri_in     = '0;
        color_in   = '0;
        repeat (3) step();

        // Reset state
        chk("rst_ready", halt_RnnnnL, 1);
        chk("rst_valid", validSamp_R14H, 0);
        chk("rst_sx", s_x_out, 0);
        chk("rst_sy", s_y_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_jitter", {jit_x_out, jit_y_out}, 0);
        chk("rst_tri", tri_out, 0);
        chk("rst_color", color_out, 0);
        rst = 1'b1;
        step();

        // 4x subsample sweep, 3x3 grid
        send_box(0, 0, 1024, 1024, 2);
        wait_idle("sweep");
        chk("sweep_count", box_hs, 9);
        chk("sweep_obs", obs_q.size(), 9);
        if (obs_q.size() > 1) begin
            chk("sweep_s1_sjx", obs_q[1][63:40], 528);
            chk("sweep_s1_sjy", obs_q[1][39:16], 256);
            chk("sweep_s1_jx", obs_q[1][15:8], 4);
            chk("sweep_s1_jy", obs_q[1][7:0], 64);
        end

        // Degenerate box: exactly one sample
        send_box(2048, 2048, 2048, 2048, $urandom_range(0, 3));
        wait_idle("degen");
        chk("degen_count", box_hs, 1);

        // Invalid box: one busy cycle, no samples
        send_box(1024, 0, 0, 1024, 2);
        chk("inv_busy", halt_RnnnnL, 0);
        chk("inv_valid", validSamp_R14H, 0);
        step();
        chk("inv_ready", halt_RnnnnL, 1);
        chk("inv_count", box_hs, 0);

        // Back-to-back boxes: one idle cycle between last and first sample
        hs_cyc_q.delete();
        send_box(0, 0, 0, 0, 0);
        send_box(4096, 0, 4096, 0, 1);
        wait_idle("b2b");
        chk("b2b_hs", hs_cyc_q.size(), 2);
        if (hs_cyc_q.size() == 2) chk("b2b_gap", hs_cyc_q[1] - hs_cyc_q[0], 2);

        // Stall 5 cycles on the third sample
        send_box(0, 0, 1024, 1024, 2);
        n = 0;
        while (!(box_hs == 2 && validSamp_R14H) && n < 100) begin
            step();
            n++;
        end
        chk("stall_reach", box_hs, 2);
        halt_R14L = 1'b0;
        repeat (5) step();
        halt_R14L = 1'b1;
        wait_idle("stall");
        chk("stall_count", box_hs, 9);

        // Reset during the fourth sample
        send_box(0, 0, 1024, 1024, 2);
        n = 0;
        while (!(box_hs == 3 && validSamp_R14H) && n < 100) begin
            step();
            n++;
        end
        chk("mrst_reach", box_hs, 3);
        rst = 1'b0;
        #1;
        chk("mrst_valid", validSamp_R14H, 0);
        chk("mrst_ready", halt_RnnnnL, 1);
        chk("mrst_sx", s_x_out, 0);
        exp_q.delete();
        repeat (3) step();
        rst = 1'b1;
        repeat (15) step();
        chk("mrst_nomore", box_hs, 3);
        chk("mrst_idle", halt_RnnnnL, 1);

        // Randomized boxes with random downstream stalls
        rand_stall = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int ss_idx, ss, pitch, llx, lly, urx, ury, w, h, kind, exp_cnt;
            ss_idx = int'($urandom_range(0, 3));
            ss     = 3 - ss_idx;
            pitch  = 1 << (RADIX - ss);
            llx    = int'($urandom_range(0, 20000)) - 10000;
            lly    = int'($urandom_range(0, 20000)) - 10000;
            kind   = int'($urandom_range(0, 7));
            w      = int'($urandom_range(0, 3)) * pitch + int'($urandom_range(0, pitch - 1));
            h      = (kind < 4) ? w
                   : int'($urandom_range(0, 3)) * pitch + int'($urandom_range(0, pitch - 1));
            urx    = (kind == 7) ? llx - int'($urandom_range(1, 300)) : llx + w;
            ury    = lly + h;
            if (urx < llx || ury < lly) exp_cnt = 0;
            else exp_cnt = ((urx - llx) / pitch + 1) * ((ury - lly) / pitch + 1);
            send_box(llx, lly, urx, ury, ss_idx);
            wait_idle("rand");
            chk("rand_count", box_hs, exp_cnt);
        end
        rand_stall = 1'b0;
        step();
        halt_R14L = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
